// File: rtl/board_pkg.sv
// Shared constants, types and address helpers for the board tile store.
package board_pkg;
  localparam int BOARD_DIM = 16;
  localparam int TILE_W    = 8;
  localparam int ADR_W     = 10;
  localparam int DEPTH     = BOARD_DIM * BOARD_DIM;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CRD_W     = ADR_W / 2;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CRD_W-1:0]  crd_t;

  localparam tile_t CLEAR_VAL = 8'h00;

  typedef enum logic [2:0] {IDLE, RD_WAIT, ACK, ERR, CLEAR} brd_state_t;

  // Bus request as seen by the responder, address split into row/col.
  typedef struct packed {
    logic  we;
    crd_t  row;
    crd_t  col;
    tile_t dat;
  } bus_req_t;

  function automatic logic in_range(crd_t row, crd_t col);
    return (int'(row) < BOARD_DIM) && (int'(col) < BOARD_DIM);
  endfunction

  // Only meaningful once in_range() holds; wraps silently otherwise.
  function automatic idx_t lin_idx(crd_t row, crd_t col);
    return idx_t'(row) * idx_t'(BOARD_DIM) + idx_t'(col);
  endfunction
endpackage

// File: rtl/board_ram.sv
// Single-port synchronous tile RAM, read-first, registered read port.
module board_ram
  import board_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   addr,
  input  logic [TILE_W-1:0]  wdata,
  output logic [TILE_W-1:0]  rdata
);
  tile_t mem [DEPTH];

  // Read returns the pre-write contents when reading and writing one address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/board_wb_responder.sv
// Wishbone classic responder for the board tile store with a clear sweep.
module board_wb_responder
  import board_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [ADR_W-1:0]   wb_adr_i,
  input  logic [TILE_W-1:0]  wb_dat_i,
  output logic [TILE_W-1:0]  wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic               clear_done
);
  brd_state_t state, state_n;
  bus_req_t   req;
  logic       req_vld, pend, done_q, done_set;
  idx_t       cnt;
  logic       ram_we;
  idx_t       ram_addr;
  tile_t      ram_wdata, ram_rdata;

  assign req     = '{we: wb_we_i, row: wb_adr_i[ADR_W-1:CRD_W],
                     col: wb_adr_i[CRD_W-1:0], dat: wb_dat_i};
  assign req_vld = wb_cyc_i & wb_stb_i;

  board_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next state plus RAM port mux: the sweep owns the RAM while in CLEAR.
  always_comb begin
    state_n   = state;
    ram_we    = 1'b0;
    ram_addr  = lin_idx(req.row, req.col);
    ram_wdata = req.dat;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req || pend) begin
          state_n = CLEAR;
        end else if (req_vld) begin
          if (!in_range(req.row, req.col)) begin
            state_n = ERR;
          end else if (req.we) begin
            ram_we  = 1'b1;
            state_n = ACK;
          end else begin
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_n = wb_cyc_i ? ACK : IDLE;
      ACK:     state_n = IDLE;
      ERR:     state_n = IDLE;
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = CLEAR_VAL;
        if (cnt == idx_t'(DEPTH - 1)) begin
          state_n  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pending clear, sweep counter, done pulse and read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= 1'b0;
      cnt      <= '0;
      done_q   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state  <= state_n;
      done_q <= done_set;
      cnt    <= (state == CLEAR) ? cnt + 1'b1 : '0;
      // IDLE always consumes the flag by launching the sweep.
      if (state == IDLE)                         pend <= 1'b0;
      else if (clear_req && state != CLEAR)      pend <= 1'b1;
      if (state == RD_WAIT && wb_cyc_i)          wb_dat_o <= ram_rdata;
    end
  end

  assign wb_ack_o   = (state == ACK);
  assign wb_err_o   = (state == ERR);
  assign clear_busy = (state == CLEAR);
  assign clear_done = done_q;
endmodule

// File: tb/tb_board_wb_responder.sv
// Scoreboard bench for board_wb_responder.
module tb_board_wb_responder;
  logic       clk, rst_n;
  logic       wb_cyc_i, wb_stb_i, wb_we_i;
  logic [9:0] wb_adr_i;
  logic [7:0] wb_dat_i, wb_dat_o;
  logic       wb_ack_o, wb_err_o;
  logic       clear_req, clear_busy, clear_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         err;
    bit         chk;
    logic [7:0] dat;
    string      name;
  } exp_t;
  exp_t sb[$];

  board_wb_responder dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Every termination pops the scoreboard and is checked against it.
  always @(negedge clk) begin
    if (rst_n && (wb_ack_o || wb_err_o)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected ack=%0b err=%0b dat=%h (no request pending)",
                 wb_ack_o, wb_err_o, wb_dat_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_err_o !== e.err || wb_ack_o !== !e.err || (e.chk && wb_dat_o !== e.dat)) begin
          n_err++;
          $display("FAIL sb_%s got ack=%0b err=%0b dat=%h, want err=%0b dat=%h",
                   e.name, wb_ack_o, wb_err_o, wb_dat_o, e.err, e.dat);
        end
      end
    end
  end

  function automatic logic [9:0] adr(int r, int c);
    return {5'(r), 5'(c)};
  endfunction

  task automatic push_exp(input bit err, input bit chk, input logic [7:0] dat, input string name);
    exp_t e;
    e.err = err; e.chk = chk; e.dat = dat; e.name = name;
    sb.push_back(e);
  endtask

  // Drive one request from a negedge; lat = cycles to termination, 0 on timeout.
  task automatic bus_cycle(input logic we, input logic [9:0] a, input logic [7:0] d, output int lat);
    lat = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) begin lat = i; break; end
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = '0; wb_dat_i = '0; clear_req = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wb_ack_o, wb_err_o, clear_busy, clear_done, wb_dat_o} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs got ack=%0b err=%0b busy=%0b done=%0b dat=%h, want all 0",
               wb_ack_o, wb_err_o, clear_busy, clear_done, wb_dat_o);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    push_exp(0, 0, 8'h00, "wr_3_5");
    bus_cycle(1, adr(3, 5), 8'hA7, lat);
    n_vec++;
    if (lat != 1) begin n_err++; $display("FAIL wr_latency got %0d want 1", lat); end
    push_exp(0, 1, 8'hA7, "rd_3_5");
    bus_cycle(0, adr(3, 5), 8'h00, lat);
    n_vec++;
    if (lat != 2) begin n_err++; $display("FAIL rd_latency got %0d want 2", lat); end
    push_exp(0, 0, 8'h00, "wr_15_15"); bus_cycle(1, adr(15, 15), 8'h3C, lat);
    push_exp(0, 0, 8'h00, "wr_0_0");   bus_cycle(1, adr(0, 0),   8'hC3, lat);
    push_exp(0, 0, 8'h00, "wr_3_0");   bus_cycle(1, adr(3, 0),   8'h11, lat);
    push_exp(0, 1, 8'h3C, "rd_15_15"); bus_cycle(0, adr(15, 15), 8'h00, lat);
  endtask

  task automatic test_err();
    int lat;
    push_exp(1, 0, 8'h00, "err_rd_16_0");
    bus_cycle(0, adr(16, 0), 8'h00, lat);
    n_vec++;
    if (lat != 1) begin n_err++; $display("FAIL err_latency got %0d want 1", lat); end
    push_exp(0, 1, 8'hC3, "rd_0_0_after_err"); bus_cycle(0, adr(0, 0), 8'h00, lat);
    // {2,16} would alias tile {3,0} if the range check were skipped.
    push_exp(1, 0, 8'h00, "err_wr_2_16");      bus_cycle(1, adr(2, 16), 8'hFF, lat);
    push_exp(0, 1, 8'h11, "rd_3_0_untouched"); bus_cycle(0, adr(3, 0), 8'h00, lat);
  endtask

  task automatic test_clear_stall();
    int busy_n = 0, done_n = 0, done_at = 0, ack_at = 0;
    push_exp(0, 1, 8'h00, "stalled_rd");
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = adr(3, 5); clear_req = 1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      clear_req = 0;
      if (clear_busy) busy_n++;
      if (clear_done) begin done_n++; done_at = i; if (clear_busy) busy_n += 1000; end
      if (wb_ack_o || wb_err_o) begin ack_at = i; break; end
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk);
    n_vec++;
    if (busy_n != 256) begin n_err++; $display("FAIL stall_busy_cycles got %0d want 256", busy_n); end
    n_vec++;
    if (done_n != 1 || done_at != 257) begin
      n_err++; $display("FAIL stall_done got count=%0d at=%0d want count=1 at=257", done_n, done_at);
    end
    n_vec++;
    if (ack_at != 259) begin n_err++; $display("FAIL stall_ack_cycle got %0d want 259", ack_at); end
  endtask

  task automatic test_clear_fill();
    int lat, busy_n = 0, done_n = 0, tmo = 0;
    for (int t = 0; t < 256; t++) begin
      push_exp(0, 0, 8'h00, "fill_5a");
      bus_cycle(1, adr(t / 16, t % 16), 8'h5A, lat);
      if (lat == 0) tmo++;
    end
    n_vec++;
    if (tmo != 0) begin n_err++; $display("FAIL fill_timeouts got %0d want 0", tmo); end
    push_exp(0, 1, 8'h5A, "rd_15_15_filled"); bus_cycle(0, adr(15, 15), 8'h00, lat);
    clear_req = 1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      clear_req = (i == 50);
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
    end
    clear_req = 0;
    n_vec++;
    if (busy_n != 256 || done_n != 1) begin
      n_err++; $display("FAIL midsweep_req got busy=%0d done=%0d want busy=256 done=1", busy_n, done_n);
    end
    push_exp(0, 1, 8'h00, "rd_15_15_cleared"); bus_cycle(0, adr(15, 15), 8'h00, lat);
    push_exp(0, 1, 8'h00, "rd_0_0_cleared");   bus_cycle(0, adr(0, 0),   8'h00, lat);
  endtask

  task automatic test_abort();
    int lat, term = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = adr(3, 5);
    @(negedge clk);
    wb_cyc_i = 0; wb_stb_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) term++;
    end
    n_vec++;
    if (term != 0) begin n_err++; $display("FAIL abort_termination got %0d want 0", term); end
    push_exp(0, 0, 8'h00, "wr_after_abort");
    bus_cycle(1, adr(1, 1), 8'h99, lat);
    n_vec++;
    if (lat != 1) begin n_err++; $display("FAIL abort_wr_latency got %0d want 1", lat); end
    push_exp(0, 1, 8'h99, "rd_1_1"); bus_cycle(0, adr(1, 1), 8'h00, lat);
  endtask

  task automatic test_reset_mid_sweep();
    int lat, k = 0;
    int chk_t[5] = '{99, 100, 200, 255, 0};
    for (int t = 0; t < 256; t++) begin
      push_exp(0, 0, 8'h00, "fill_pat");
      bus_cycle(1, adr(t / 16, t % 16), 8'(t) ^ 8'hA5, lat);
    end
    clear_req = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      clear_req = 0;
      if (clear_busy) k++;
      if (k == 101) break;
    end
    rst_n = 0;
    #1;
    n_vec++;
    if ({wb_ack_o, wb_err_o, clear_busy, clear_done, wb_dat_o} !== 12'h0 || k != 101) begin
      n_err++;
      $display("FAIL async_reset got ack=%0b err=%0b busy=%0b done=%0b dat=%h k=%0d, want all 0 k=101",
               wb_ack_o, wb_err_o, clear_busy, clear_done, wb_dat_o, k);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    foreach (chk_t[j]) begin
      int t;
      t = chk_t[j];
      push_exp(0, 1, (t < 100) ? 8'h00 : (8'(t) ^ 8'hA5), $sformatf("rd_after_rst_%0d", t));
      bus_cycle(0, adr(t / 16, t % 16), 8'h00, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_err();
    test_clear_stall();
    test_clear_fill();
    test_abort();
    test_reset_mid_sweep();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_leftover got %0d outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
